// File: rtl/piso_serializer_pkg.sv
// rtl/piso_serializer_pkg.sv - shared types and helpers for the PISO serializer
//
// Purpose : FSM state encoding and counter sizing shared by the serializer
//           and by benches on the detector side.
// Contents: state_t (ST_IDLE, ST_SHIFT), cnt_width(width).

package piso_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit counter width for a word of 'width' bits; counts 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer_shift_core.sv
// rtl/piso_serializer_shift_core.sv - shift register plus bit counter for the PISO serializer
//
// Purpose : Holds the word being serialized, presents the current bit and
//           flags when that bit is the last one of the word.
// Ports   : clk, rst (async active-low)
//           load, load_data - capture a new word, counter to 0
//           step            - advance to the next bit (ignored on the last bit)
//           bit_out         - current bit, straight from the register
//           last            - current bit is bit WIDTH-1 of the sequence

module piso_serializer_shift_core
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             step,
  output logic             bit_out,
  output logic             last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '0;
    end else if (step && !last) begin
      // The outgoing bit always sits at the end bit_out reads from.
      if (MSB_FIRST) sreg <= {sreg[WIDTH-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[WIDTH-1:1]};
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_out = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign last    = (cnt == LAST_CNT);

endmodule

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in/serial-out stage feeding a bit-serial detector
//
// Purpose : Accepts WIDTH-bit words over valid/ready and shifts them out one
//           bit per bit_en cycle, back-to-back without idle bits.
// Ports   : clk, rst (async active-low), bit_en (bit-rate enable)
//           in_valid, in_ready, in_data - word handshake (in_ready is combinational)
//           dout, dout_valid           - serial bit and its qualifier
//           busy                       - a word is loaded or shifting
//           word_done                  - pulse on the final bit_en of a word

module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             word_done
);

  state_t state, state_nxt;
  logic   load, step, bit_out, last, xfer;

  piso_serializer_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift_core (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(in_data),
    .step     (step),
    .bit_out  (bit_out),
    .last     (last)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (xfer) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_en && last && !xfer) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs. A new word may only enter on the final bit_en of the current
  // one, which is what makes the stream gapless.
  always_comb begin
    in_ready   = 1'b0;
    load       = 1'b0;
    step       = 1'b0;
    word_done  = 1'b0;
    busy       = (state == ST_SHIFT);
    dout_valid = (state == ST_SHIFT);
    dout       = (state == ST_SHIFT) ? bit_out : IDLE_LEVEL;
    if (rst) begin
      if (state == ST_IDLE) in_ready = 1'b1;
      else                  in_ready = last && bit_en;
    end
    load = xfer;
    if (state == ST_SHIFT && bit_en) begin
      step      = !last;
      word_done = last;
    end
  end

  assign xfer = in_valid && in_ready;

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer

module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst, bit_en, in_valid;
  logic [7:0] in_data;
  logic       rdy_a, dout_a, dv_a, busy_a, wd_a;
  logic       rdy_b, dout_b, dv_b, busy_b, wd_b;

  int n_cmp  = 0;
  int n_fail = 0;

  logic q_a[$], ql_a[$], q_b[$], ql_b[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .dout(dout_a), .dout_valid(dv_a), .busy(busy_a), .word_done(wd_a)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bit_en(bit_en), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .dout(dout_b), .dout_valid(dv_b), .busy(busy_b), .word_done(wd_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Scoreboard: expected bits are queued at the transfer and popped on the
  // final bit_en cycle of each bit, together with the expected word_done.
  always @(negedge clk) begin
    logic eb, el;
    if (rst) begin
      if (bit_en && dv_a) begin
        check("sb_avail_a", 32'(q_a.size() != 0), 32'd1);
        if (q_a.size() != 0) begin
          eb = q_a.pop_front();
          el = ql_a.pop_front();
          check("sb_bit_a", 32'(dout_a), 32'(eb));
          check("sb_done_a", 32'(wd_a), 32'(el));
        end
      end
      if (bit_en && dv_b) begin
        check("sb_avail_b", 32'(q_b.size() != 0), 32'd1);
        if (q_b.size() != 0) begin
          eb = q_b.pop_front();
          el = ql_b.pop_front();
          check("sb_bit_b", 32'(dout_b), 32'(eb));
          check("sb_done_b", 32'(wd_b), 32'(el));
        end
      end
      if (in_valid && rdy_a)
        for (int k = 7; k >= 0; k--) begin
          q_a.push_back(in_data[k]);
          ql_a.push_back(k == 0);
        end
      if (in_valid && rdy_b)
        for (int k = 0; k < 8; k++) begin
          q_b.push_back(in_data[k]);
          ql_b.push_back(k == 7);
        end
    end
  end

  typedef struct {
    logic [7:0] data;
    int         period;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
    int         exp_busy;
  } vec_t;

  vec_t vecs[5];

  // Sends one word from IDLE and captures the bits seen on each bit_en.
  task automatic run_word(input logic [7:0] d, input int p,
                          output logic [7:0] cap_a, output logic [7:0] cap_b,
                          output int busy_n, output int wd_n);
    cap_a = '0; cap_b = '0; busy_n = 0; wd_n = 0;
    in_valid = 1'b1; in_data = d; bit_en = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    for (int c = 1; c <= 300; c++) begin
      bit_en = ((c % p) == 0);
      @(negedge clk);
      if (!dv_a) break;
      if (busy_a) busy_n++;
      if (bit_en) begin
        cap_a = {cap_a[6:0], dout_a};
        cap_b = {cap_b[6:0], dout_b};
      end
      if (wd_a) wd_n++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    bit_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ca, cb;
    logic [15:0] s_a, s_b;
    int          bn, wn, acc, vcount, rdy_pos, rdy_hits, gap;

    vecs[0] = '{8'hB5, 1, 8'hB5, 8'hAD, 8};
    vecs[1] = '{8'h81, 4, 8'h81, 8'h81, 32};
    vecs[2] = '{8'h01, 1, 8'h01, 8'h80, 8};
    vecs[3] = '{8'h3C, 2, 8'h3C, 8'h3C, 16};
    vecs[4] = '{8'hE2, 3, 8'hE2, 8'h47, 24};

    rst = 1'b0; bit_en = 1'b0; in_valid = 1'b0; in_data = '0;

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", 32'(rdy_a), 32'd0);
      check("rst_dout", 32'(dout_a), 32'd0);
      check("rst_dout_valid", 32'(dv_a), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;

    // Idle with bit_en active: nothing moves
    for (int c = 0; c < 3; c++) begin
      bit_en = 1'b1;
      @(negedge clk);
      check("idle_dout", 32'(dout_a), 32'd0);
      check("idle_dout_valid", 32'(dv_a), 32'd0);
      check("idle_in_ready", 32'(rdy_a), 32'd1);
      check("idle_busy", 32'(busy_a), 32'd0);
      check("idle_word_done", 32'(wd_a), 32'd0);
      @(posedge clk); #1;
    end
    bit_en = 1'b0;

    // Table of single words at various bit rates
    for (int i = 0; i < 5; i++) begin
      run_word(vecs[i].data, vecs[i].period, ca, cb, bn, wn);
      check($sformatf("tbl%0d_msb_seq", i), 32'(ca), 32'(vecs[i].exp_msb));
      check($sformatf("tbl%0d_lsb_seq", i), 32'(cb), 32'(vecs[i].exp_lsb));
      check($sformatf("tbl%0d_busy_cycles", i), 32'(bn), 32'(vecs[i].exp_busy));
      check($sformatf("tbl%0d_word_done_cnt", i), 32'(wn), 32'd1);
    end

    // Back-to-back A0 then 5F with in_valid held high
    acc = 0; vcount = 0; rdy_pos = -1; rdy_hits = 0; gap = 0; s_a = '0; s_b = '0;
    in_valid = 1'b1; in_data = 8'hA0; bit_en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (dv_a) begin
        s_a = {s_a[14:0], dout_a};
        s_b = {s_b[14:0], dout_b};
        vcount++;
      end else if (vcount > 0 && vcount < 16) begin
        gap++;
      end
      if (busy_a && rdy_a && acc == 1) begin
        rdy_hits++;
        rdy_pos = vcount - 1;
      end
      if (in_valid && rdy_a) acc++;
      if (vcount >= 16 && !dv_a) break;
      @(posedge clk); #1;
      if (acc == 1) in_data = 8'h5F;
      if (acc >= 2) in_valid = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; bit_en = 1'b0;
    check("b2b_accepted", 32'(acc), 32'd2);
    check("b2b_valid_bits", 32'(vcount), 32'd16);
    check("b2b_gap", 32'(gap), 32'd0);
    check("b2b_msb_stream", 32'(s_a), 32'h0000A05F);
    check("b2b_lsb_stream", 32'(s_b), 32'h000005FA);
    check("b2b_ready_hits", 32'(rdy_hits), 32'd1);
    check("b2b_ready_pos", 32'(rdy_pos), 32'd7);

    // Reset in the middle of a word
    in_valid = 1'b1; in_data = 8'hFF; bit_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("abort_dout", 32'(dout_a), 32'd0);
    check("abort_dout_valid", 32'(dv_a), 32'd0);
    check("abort_busy", 32'(busy_a), 32'd0);
    check("abort_word_done", 32'(wd_a), 32'd0);
    check("abort_in_ready", 32'(rdy_a), 32'd0);
    q_a.delete(); ql_a.delete(); q_b.delete(); ql_b.delete();
    @(negedge clk);
    check("abort_hold_valid", 32'(dv_a), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    run_word(8'h0F, 1, ca, cb, bn, wn);
    check("post_abort_msb_seq", 32'(ca), 32'h0F);
    check("post_abort_lsb_seq", 32'(cb), 32'hF0);
    check("post_abort_word_done", 32'(wn), 32'd1);

    check("sb_drain_a", 32'(q_a.size()), 32'd0);
    check("sb_drain_b", 32'(q_b.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
